// File: rtl/message_pkg.sv
`default_nettype none
// ============================================================================
// Package     : message_pkg
// Description : Shared types and constants for the message RAM read/transmit
//               path: controller state encoding, default message length and
//               the ASCII characters stored in the message RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package message_pkg;

    // Controller states of the message reader
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    // 8 message characters plus line feed and carriage return
    localparam int DEFAULT_MSG_LEN = 10;

    // Characters shared with the message RAM
    localparam logic [7:0] CHAR_0     = 8'h30;
    localparam logic [7:0] CHAR_1     = 8'h31;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

endpackage : message_pkg
`default_nettype wire

// File: rtl/message_reader_tx.sv
`default_nettype none
// ============================================================================
// Module      : message_reader_tx
// Description : Drains the message RAM one address at a time and hands each
//               byte to the UART transmitter over the new_tx_data / tx_busy
//               handshake. A start during a pass is remembered and triggers
//               exactly one repeat pass.
// Revision    : 1.0 - initial release
// ============================================================================
module message_reader_tx
    import message_pkg::*;
#(
    parameter int MSG_LEN = DEFAULT_MSG_LEN,
    parameter int RD_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       tx_busy,
    output logic [3:0] addr,
    output logic [7:0] tx_data,
    output logic       new_tx_data,
    output logic       busy,
    output logic       done
);

    // Final RAM address of a pass and the latency counter reload value
    localparam logic [3:0] LAST_ADDR = 4'(MSG_LEN - 1);
    localparam logic [1:0] LAT_LOAD  = 2'(RD_LAT - 1);

    state_t     state_q,       state_d;
    logic [3:0] addr_q,        addr_d;
    logic [1:0] lat_cnt_q,     lat_cnt_d;
    logic       pending_q,     pending_d;
    logic [7:0] tx_data_q,     tx_data_d;
    logic       new_tx_data_q, new_tx_data_d;
    logic       done_q,        done_d;

    // Next-state and output decode; every register holds unless changed below
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        lat_cnt_d     = lat_cnt_q;
        tx_data_d     = tx_data_q;
        new_tx_data_d = 1'b0;
        done_d        = 1'b0;
        // A start seen while a pass is running (including the cycle that
        // enters FINISH) is remembered; the flag saturates at one.
        pending_d     = pending_q | (start & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                addr_d = 4'd0;
                if (start || pending_q) begin
                    pending_d = 1'b0;
                    lat_cnt_d = LAT_LOAD;
                    state_d   = READ;
                end
            end
            READ: begin
                // Wait out the RAM read latency for the current address
                if (lat_cnt_q == 2'd0) begin
                    state_d = SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            SEND: begin
                // Hold address and data while the transmitter is busy
                if (!tx_busy) begin
                    tx_data_d     = data;
                    new_tx_data_d = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = FINISH;
                    end else begin
                        addr_d    = addr_q + 4'd1;
                        lat_cnt_d = LAT_LOAD;
                        state_d   = READ;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                addr_d  = 4'd0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            addr_q        <= 4'd0;
            lat_cnt_q     <= 2'd0;
            pending_q     <= 1'b0;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            lat_cnt_q     <= lat_cnt_d;
            pending_q     <= pending_d;
            tx_data_q     <= tx_data_d;
            new_tx_data_q <= new_tx_data_d;
            done_q        <= done_d;
        end
    end

    assign addr        = addr_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);

endmodule : message_reader_tx
`default_nettype wire
